// File: rtl/dff_seq_pkg.sv
// Shared types and constants for the dff stimulus/check sequencer.
// Holds the FSM state type, the pattern mode codes and the LFSR helpers.
package dff_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_TOGGLE = 2'd0;
  localparam logic [1:0] MODE_LFSR   = 2'd1;
  localparam logic [1:0] MODE_ZERO   = 2'd2;
  localparam logic [1:0] MODE_ONE    = 2'd3;

  // Taps 8,6,5,4 (1-based) of a right-shifting Fibonacci LFSR.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {^(s & LFSR_TAPS), s[7:1]};
  endfunction

  function automatic logic pattern_bit(input logic [1:0] m, input logic k_lsb,
                                       input logic [7:0] s);
    logic b;
    case (m)
      MODE_TOGGLE: b = ~k_lsb;
      MODE_LFSR:   b = s[0];
      MODE_ZERO:   b = 1'b0;
      default:     b = 1'b1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dff_seq_exp_pipe.sv
// LAT-deep shift register of {valid, value, idx}; the tail lines up with
// the flop output for the vector it describes.
module dff_seq_exp_pipe
  import dff_seq_pkg::*;
#(
  parameter int unsigned LAT = 1,
  parameter int unsigned IW  = 8
) (
  input  logic          cp,
  input  logic          rst_n,
  input  logic          push_valid,
  input  logic          push_value,
  input  logic [IW-1:0] push_idx,
  output logic          tail_valid,
  output logic          tail_value,
  output logic [IW-1:0] tail_idx
);

  logic [LAT-1:0] vld;
  logic [LAT-1:0] val;
  logic [IW-1:0]  ix [LAT];

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      val <= '0;
      for (int unsigned i = 0; i < LAT; i++) ix[i] <= '0;
    end else begin
      vld[0] <= push_valid;
      val[0] <= push_value;
      ix[0]  <= push_idx;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        val[i] <= val[i-1];
        ix[i]  <= ix[i-1];
      end
    end
  end

  always_comb begin
    tail_valid = vld[LAT-1];
    tail_value = val[LAT-1];
    tail_idx   = ix[LAT-1];
  end

endmodule

// File: rtl/dff_seq_ctrl.sv
// Stimulus/check sequencer for a single-bit flop: issues NUM_VEC vectors on d,
// compares q against the LAT-delayed expectation, reports pass/errors/first fail.
module dff_seq_ctrl
  import dff_seq_pkg::*;
#(
  parameter int unsigned NUM_VEC = 16,
  parameter int unsigned LAT     = 1,
  parameter int unsigned IW      = 8,
  parameter int unsigned CW      = 8,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic          cp,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    mode,
  output logic          d,
  input  logic          q,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic [IW-1:0] first_fail
);

  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_VEC - 1);
  localparam logic [2:0]    DRAIN_LAST = 3'(LAT - 1);

  state_t        state, state_nxt;
  logic [1:0]    mode_q;
  logic [IW-1:0] idx;
  logic [7:0]    lfsr;
  logic [2:0]    drain_cnt;
  logic          accept, last_issue, push_valid, mismatch;
  logic          tail_valid, tail_value;
  logic [IW-1:0] tail_idx;

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_RUN;
      ST_RUN:           if (last_issue) state_nxt = ST_DRAIN;
      ST_DRAIN:         if (drain_cnt == DRAIN_LAST) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == ST_RUN) || (state == ST_DRAIN);
    done       = (state == ST_DONE);
    pass       = done && (err_count == '0);
    accept     = start && ((state == ST_IDLE) || (state == ST_DONE));
    last_issue = (idx == LAST_IDX);
    push_valid = (state == ST_RUN);
    mismatch   = tail_valid && (q != tail_value);
  end

  // Vector 0 is loaded by the accepting edge so vector k sits on d for the whole
  // of RUN cycle k; the pipe records d as the flop captures it at the cycle end.
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_TOGGLE;
      idx       <= '0;
      lfsr      <= SEED;
      d         <= 1'b0;
      drain_cnt <= '0;
    end else if (accept) begin
      mode_q <= mode;
      idx    <= '0;
      lfsr   <= lfsr_next(SEED);
      d      <= pattern_bit(mode, 1'b0, SEED);
    end else if (state == ST_RUN) begin
      drain_cnt <= '0;
      if (!last_issue) begin
        idx  <= idx + IW'(1);
        lfsr <= lfsr_next(lfsr);
        d    <= pattern_bit(mode_q, ~idx[0], lfsr);
      end
    end else if (state == ST_DRAIN) begin
      drain_cnt <= drain_cnt + 3'd1;
    end
  end

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      first_fail <= '1;
    end else if (accept) begin
      err_count  <= '0;
      first_fail <= '1;
    end else if (mismatch) begin
      if (err_count != '1) err_count <= err_count + CW'(1);
      if (err_count == '0) first_fail <= tail_idx;
    end
  end

  dff_seq_exp_pipe #(
    .LAT(LAT),
    .IW (IW)
  ) u_pipe (
    .cp        (cp),
    .rst_n     (rst_n),
    .push_valid(push_valid),
    .push_value(d),
    .push_idx  (idx),
    .tail_valid(tail_valid),
    .tail_value(tail_value),
    .tail_idx  (tail_idx)
  );

endmodule

// File: tb/tb_dff_seq_ctrl.sv
// Bench for dff_seq_ctrl: three instances (default, CW=2, NUM_VEC=1/LAT=2)
// each driving a behavioural flop; a run-level model checks instance A per cycle.
module tb_dff_seq_ctrl;

  localparam int         NV   = 16;
  localparam int         LA   = 1;
  localparam logic [7:0] SEED = 8'hA5;

  logic cp = 1'b0;
  logic rst_n = 1'b1;
  always #5 cp = ~cp;

  int total = 0;
  int bad   = 0;

  // Instance A: defaults, ideal flop with optional inversion of q.
  logic       start_a = 1'b0;
  logic [1:0] mode_a  = 2'd0;
  logic       d_a, q_a, busy_a, done_a, pass_a;
  logic [7:0] err_a, first_a;
  logic       ff_a  = 1'b0;
  logic       inj_a = 1'b0;
  assign q_a = ff_a ^ inj_a;

  // Instance B: 2-bit error counter, q tied low.
  logic       start_b = 1'b0;
  logic [1:0] mode_b  = 2'd0;
  logic       d_b, busy_b, done_b, pass_b;
  logic [1:0] err_b;
  logic [7:0] first_b;

  // Instance C: single vector, two-cycle latency.
  logic       start_c = 1'b0;
  logic [1:0] mode_c  = 2'd0;
  logic       d_c, q_c, busy_c, done_c, pass_c;
  logic [7:0] err_c, first_c;
  logic       p1_c = 1'b0;
  logic       p2_c = 1'b0;
  assign q_c = p2_c;

  dff_seq_ctrl u_dut_a (
    .cp(cp), .rst_n(rst_n), .start(start_a), .mode(mode_a), .d(d_a), .q(q_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail(first_a)
  );

  dff_seq_ctrl #(.CW(2)) u_dut_b (
    .cp(cp), .rst_n(rst_n), .start(start_b), .mode(mode_b), .d(d_b), .q(1'b0),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_fail(first_b)
  );

  dff_seq_ctrl #(.NUM_VEC(1), .LAT(2)) u_dut_c (
    .cp(cp), .rst_n(rst_n), .start(start_c), .mode(mode_c), .d(d_c), .q(q_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .first_fail(first_c)
  );

  initial forever begin
    @(posedge cp);
    ff_a <= d_a;
    p1_c <= d_c;
    p2_c <= p1_c;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Run model for A: cyc is the cycle number since the accepted start
  // (-1 when not running); a run occupies NV+LA busy cycles.
  int         cyc    = -1;
  bit         mdone  = 1'b0;
  bit         mfresh = 1'b1;
  bit         exp_vec [NV];
  logic [15:0] fault_a = '0;
  logic [15:0] mfault  = '0;
  int         m_err   = 0;
  logic [7:0] m_first = 8'hFF;

  task automatic load_model(input logic [1:0] m);
    logic [7:0] s;
    s       = SEED;
    m_err   = 0;
    m_first = 8'hFF;
    mfault  = fault_a;
    for (int k = 0; k < NV; k++) begin
      case (m)
        2'd0:    exp_vec[k] = (k % 2 == 0);
        2'd1:    exp_vec[k] = s[0];
        2'd2:    exp_vec[k] = 1'b0;
        default: exp_vec[k] = 1'b1;
      endcase
      s = {s[7] ^ s[5] ^ s[4] ^ s[3], s[7:1]};
      if (fault_a[k]) begin
        if (m_err == 0) m_first = 8'(k);
        m_err++;
      end
    end
  endtask

  initial forever begin
    @(posedge cp or negedge rst_n);
    if (!rst_n) begin
      cyc    = -1;
      mdone  = 1'b0;
      mfresh = 1'b1;
    end else if (cyc < 0) begin
      if (start_a) begin
        load_model(mode_a);
        cyc    = 0;
        mdone  = 1'b0;
        mfresh = 1'b0;
      end
    end else if (cyc == NV + LA - 1) begin
      cyc   = -1;
      mdone = 1'b1;
    end else begin
      cyc++;
    end
  end

  // Invert q in the cycle where the flop presents a faulted vector.
  initial forever begin
    @(negedge cp);
    if (cyc >= LA && cyc - LA < NV) inj_a = mfault[cyc-LA];
    else                            inj_a = 1'b0;
  end

  initial forever begin
    @(negedge cp);
    chk("a_busy", 32'(busy_a), 32'(cyc >= 0));
    chk("a_done", 32'(done_a), 32'(mdone));
    if (cyc >= 0 && cyc < NV) chk("a_d", 32'(d_a), 32'(exp_vec[cyc]));
    if (mdone) begin
      chk("a_d_hold", 32'(d_a), 32'(exp_vec[NV-1]));
      chk("a_pass", 32'(pass_a), 32'(m_err == 0));
      chk("a_err", 32'(err_a), 32'(m_err));
      chk("a_first", 32'(first_a), 32'(m_first));
    end
    if (mfresh) begin
      chk("a_rst_d", 32'(d_a), 32'd0);
      chk("a_rst_err", 32'(err_a), 32'd0);
      chk("a_rst_first", 32'(first_a), 32'hFF);
      chk("a_rst_pass", 32'(pass_a), 32'd0);
    end
  end

  int   busy_cnt_a   = 0;
  int   done_rises_a = 0;
  int   busy_cnt_c   = 0;
  logic done_prev_a  = 1'b0;
  logic dlog [4];

  initial forever begin
    @(negedge cp);
    if (busy_a) begin
      if (busy_cnt_a < 4) dlog[busy_cnt_a] = d_a;
      busy_cnt_a++;
    end
    if (done_a && !done_prev_a) done_rises_a++;
    done_prev_a = done_a;
    if (busy_c) busy_cnt_c++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge cp);
      #1;
    end
  endtask

  task automatic clr_counters();
    busy_cnt_a   = 0;
    done_rises_a = 0;
    for (int i = 0; i < 4; i++) dlog[i] = 1'b0;
  endtask

  task automatic pulse_a(input logic [1:0] m, input logic [15:0] f);
    mode_a  = m;
    fault_a = f;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
  endtask

  task automatic wait_done(input int which, input string nm);
    int n;
    n = 0;
    while (n < 200 && !((which == 0) ? done_a : (which == 1) ? done_b : done_c)) begin
      tick(1);
      n++;
    end
    chk({nm, "_timeout"}, 32'(n < 200), 32'd1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Toggle run with a second start and a mode change mid-run.
    clr_counters();
    pulse_a(2'd0, 16'h0000);
    tick(3);
    start_a = 1'b1;
    mode_a  = 2'd2;
    tick(1);
    start_a = 1'b0;
    wait_done(0, "tog");
    tick(1);
    chk("tog_busy_cycles", 32'(busy_cnt_a), 32'd17);
    chk("tog_done_once", 32'(done_rises_a), 32'd1);
    chk("tog_first4", 32'({dlog[0], dlog[1], dlog[2], dlog[3]}), 32'b1010);
    chk("tog_pass", 32'(pass_a), 32'd1);
    chk("tog_err", 32'(err_a), 32'd0);
    chk("tog_first", 32'(first_a), 32'hFF);

    // Faults on vectors 3 and 7.
    pulse_a(2'd0, 16'h0088);
    wait_done(0, "flt");
    chk("flt_err", 32'(err_a), 32'd2);
    chk("flt_first", 32'(first_a), 32'd3);
    chk("flt_pass", 32'(pass_a), 32'd0);

    // Relaunch from DONE in LFSR mode clears the counters.
    clr_counters();
    pulse_a(2'd1, 16'h0000);
    chk("rel_err_clr", 32'(err_a), 32'd0);
    chk("rel_first_clr", 32'(first_a), 32'hFF);
    chk("rel_done_drop", 32'(done_a), 32'd0);
    wait_done(0, "lfsr");
    chk("lfsr_first4", 32'({dlog[0], dlog[1], dlog[2], dlog[3]}), 32'b1010);
    chk("lfsr_pass", 32'(pass_a), 32'd1);

    // Faults on the first and last vectors.
    pulse_a(2'd3, 16'h8001);
    wait_done(0, "edge");
    chk("edge_err", 32'(err_a), 32'd2);
    chk("edge_first", 32'(first_a), 32'd0);

    // Start coincident with the DRAIN->DONE edge is ignored.
    pulse_a(2'd2, 16'h0000);
    tick(16);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    chk("coinc_done", 32'(done_a), 32'd1);
    tick(2);
    chk("coinc_still_done", 32'(done_a), 32'd1);
    chk("coinc_busy", 32'(busy_a), 32'd0);

    // Reset during RUN cycle 5, then a clean run.
    clr_counters();
    pulse_a(2'd0, 16'h0000);
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_done", 32'(done_a), 32'd0);
    chk("mid_rst_d", 32'(d_a), 32'd0);
    chk("mid_rst_err", 32'(err_a), 32'd0);
    chk("mid_rst_first", 32'(first_a), 32'hFF);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clr_counters();
    pulse_a(2'd2, 16'h0000);
    wait_done(0, "post_rst");
    tick(1);
    chk("post_rst_busy_cycles", 32'(busy_cnt_a), 32'd17);
    chk("post_rst_pass", 32'(pass_a), 32'd1);

    // Saturating 2-bit counter.
    mode_b  = 2'd3;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    wait_done(1, "sat");
    chk("sat_err", 32'(err_b), 32'd3);
    chk("sat_first", 32'(first_b), 32'd0);
    chk("sat_pass", 32'(pass_b), 32'd0);

    // Single vector with two-cycle latency.
    busy_cnt_c = 0;
    mode_c     = 2'd0;
    start_c    = 1'b1;
    tick(1);
    start_c = 1'b0;
    wait_done(2, "one");
    chk("one_busy_cycles", 32'(busy_cnt_c), 32'd3);
    chk("one_d", 32'(d_c), 32'd1);
    chk("one_pass", 32'(pass_c), 32'd1);
    chk("one_err", 32'(err_c), 32'd0);
    chk("one_first", 32'(first_c), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1);
  end

endmodule
